// File: rtl/lsu_align_pkg.sv
// Shared control constants, state encoding and lane helpers for the load/store aligner.
package lsu_align_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] size_byte = 2'b00;
  localparam logic [1:0] size_half = 2'b01;
  localparam logic [1:0] size_word = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

  // Reserved size or an offset not naturally aligned to the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      size_byte: is_misaligned = 1'b0;
      size_half: is_misaligned = off[0];
      size_word: is_misaligned = (off != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      size_byte: store_be = 4'b0001 << off;
      size_half: store_be = off[1] ? 4'b1100 : 4'b0011;
      size_word: store_be = 4'b1111;
      default:   store_be = 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so the enables pick the right copy.
  function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    case (size)
      size_byte: store_data = {4{wdata[7:0]}};
      size_half: store_data = {2{wdata[15:0]}};
      default:   store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Req/ack data bus between the load/store unit (master) and memory (slave).
interface lsu_align_if;
  import lsu_align_pkg::*;

  logic            BusReq;
  logic            BusWe;
  logic [XLEN-1:0] BusAddr;
  logic [3:0]      BusBE;
  logic [XLEN-1:0] BusWData;
  logic [XLEN-1:0] BusRData;
  logic            BusAck;

  modport master (
    output BusReq, BusWe, BusAddr, BusBE, BusWData,
    input  BusRData, BusAck
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusBE, BusWData,
    output BusRData, BusAck
  );
endinterface

// File: rtl/lsu_align_load_ext.sv
// Load lane select plus zero/sign extension to a full word.
module load_ext
  import lsu_align_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            sext,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/half and extend it per sext.
  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    result = '0;
    case (size)
      size_byte: result = {{24{sext & lane_b[7]}}, lane_b};
      size_half: result = {{16{sext & lane_h[15]}}, lane_h};
      size_word: result = rdata;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Memory-stage load/store aligner: lane steering, bus handshake, stall and timeout.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Req,
  input  logic            We,
  input  logic [1:0]      Size,
  input  logic            Sext,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WData,
  output logic [XLEN-1:0] RData,
  output logic            Stall,
  output logic            AdEL,
  output logic            AdES,
  output logic            BusErr,
  lsu_align_if.master     bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   ext_result;
  logic              misaligned;

  assign misaligned = is_misaligned(Size, Addr[1:0]);

  // Next-state, captured access and combinational pipeline controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    Stall   = 1'b0;
    AdEL    = 1'b0;
    AdES    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          if (misaligned) begin
            AdEL = ~We;
            AdES = We;
          end else begin
            Stall       = 1'b1;
            req_d       = 1'b1;
            cmd_d.we    = We;
            cmd_d.addr  = {Addr[XLEN-1:2], 2'b00};
            cmd_d.be    = store_be(Size, Addr[1:0]);
            cmd_d.wdata = store_data(Size, WData);
            size_d      = Size;
            sext_d      = Sext;
            off_d       = Addr[1:0];
            cnt_d       = '0;
            err_d       = 1'b0;
            state_d     = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        Stall = 1'b1;
        if (bus.BusAck) begin
          rdata_d = bus.BusRData;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          rdata_d = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and access registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  load_ext u_load_ext (
    .rdata  (rdata_q),
    .off    (off_q),
    .size   (size_q),
    .sext   (sext_q),
    .result (ext_result)
  );

  assign RData        = (state_q == ST_DONE) ? ext_result : '0;
  assign BusErr       = err_q;
  assign bus.BusReq   = req_q;
  assign bus.BusWe    = cmd_q.we;
  assign bus.BusAddr  = cmd_q.addr;
  assign bus.BusBE    = cmd_q.be;
  assign bus.BusWData = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-level behavioural model and per-cycle compare.
module tb_lsu_align;

  localparam int unsigned WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req, We, Sext;
  logic [1:0]  Size;
  logic [31:0] Addr, WData, RData;
  logic        Stall, AdEL, AdES, BusErr;

  lsu_align_if bus ();

  lsu_align #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk    (clk),
    .reset  (reset),
    .Req    (Req),
    .We     (We),
    .Size   (Size),
    .Sext   (Sext),
    .Addr   (Addr),
    .WData  (WData),
    .RData  (RData),
    .Stall  (Stall),
    .AdEL   (AdEL),
    .AdES   (AdES),
    .BusErr (BusErr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access covers n = 2**size bytes starting at the n-aligned byte offset.
  function automatic bit m_misal(input logic [1:0] s, input logic [31:0] a);
    int n = 1 << s;
    int o = int'(a[1:0]);
    return (s == 2'd3) || ((o % n) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    int n = 1 << s;
    int o = int'(a[1:0]);
    int st = o - (o % n);
    logic [3:0] be = '0;
    for (int j = 0; j < 4; j++) be[j] = (j >= st) && (j < st + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    int n = 1 << s;
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = w[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] s, input logic sx,
                                          input logic [31:0] a, input logic [31:0] rd);
    int n = 1 << s;
    int o = int'(a[1:0]);
    int st = o - (o % n);
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v = ({32'd0, rd} >> (8 * st)) & mask;
    if (sx && (((v >> (8 * n - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v[31:0];
  endfunction

  // Expectations written by the stimulus process, compared every cycle.
  logic        chk_en = 1'b0, chk_bus = 1'b0, chk_rd = 1'b0;
  logic        e_stall, e_req, e_adel, e_ades, e_err, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (chk_en) begin
      check("Stall",  32'(Stall),      32'(e_stall));
      check("BusReq", 32'(bus.BusReq), 32'(e_req));
      check("AdEL",   32'(AdEL),       32'(e_adel));
      check("AdES",   32'(AdES),       32'(e_ades));
      check("BusErr", 32'(BusErr),     32'(e_err));
      if (chk_bus) begin
        check("BusWe",    32'(bus.BusWe), 32'(e_we));
        check("BusAddr",  bus.BusAddr,    e_addr);
        check("BusBE",    32'(bus.BusBE), 32'(e_be));
        check("BusWData", bus.BusWData,   e_wdata);
      end
      if (chk_rd) check("RData", RData, e_rdata);
    end
  end

  task automatic set_idle();
    e_stall = 1'b0; e_req = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_err = 1'b0;
    chk_bus = 1'b0; chk_rd = 1'b0;
  endtask

  // One access; nack = BUSY cycles without ack before the ack (>= WAIT_MAX means timeout).
  task automatic txn(input logic we, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int nack, input bit late_ack);
    bit mis = m_misal(sz, a);
    bit timed = 1'b1;
    @(posedge clk); #1;
    Req = 1'b1; We = we; Size = sz; Sext = sx; Addr = a; WData = wd; bus.BusAck = 1'b0;
    set_idle();
    e_stall = !mis; e_adel = mis && !we; e_ades = mis && we;
    if (mis) begin
      @(posedge clk); #1;
      Req = 1'b0;
      set_idle();
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < int'(WAIT_MAX); i++) begin
      @(posedge clk); #1;
      e_stall = 1'b1; e_req = 1'b1; e_adel = 1'b0; e_ades = 1'b0;
      chk_bus = 1'b1; e_we = we; e_addr = {a[31:2], 2'b00};
      e_be = m_be(sz, a); e_wdata = m_wdata(sz, wd);
      if (i == nack) begin
        bus.BusAck = 1'b1; bus.BusRData = rd; timed = 1'b0;
        break;
      end
      bus.BusRData = ~rd;
    end
    @(posedge clk); #1;
    bus.BusAck = 1'b0; bus.BusRData = 32'hDEADBEEF; Req = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; chk_bus = 1'b0; e_err = timed;
    chk_rd = !we; e_rdata = timed ? 32'd0 : m_rdata(sz, sx, a, rd);
    @(posedge clk); #1;
    set_idle();
    if (late_ack) bus.BusAck = 1'b1;
    @(posedge clk); #1;
    bus.BusAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; We = 1'b0; Size = 2'b00; Sext = 1'b0;
    Addr = '0; WData = '0; bus.BusAck = 1'b0; bus.BusRData = '0;

    // Model pins from hand-computed values.
    check("pin_be_byte3",   32'(m_be(2'b00, 32'h1003)), 32'h8);
    check("pin_wd_byte",    m_wdata(2'b00, 32'h000000A5), 32'hA5A5A5A5);
    check("pin_rd_half_s",  m_rdata(2'b01, 1'b1, 32'h2002, 32'h80011234), 32'hFFFF8001);
    check("pin_rd_half_u",  m_rdata(2'b01, 1'b0, 32'h2002, 32'h80011234), 32'h00008001);
    check("pin_rd_byte_u",  m_rdata(2'b00, 1'b0, 32'h2001, 32'h11223344), 32'h00000033);
    check("pin_mis_word",   32'(m_misal(2'b10, 32'h3002)), 32'd1);

    // Reset state: every output zero.
    @(posedge clk); #1;
    set_idle();
    chk_bus = 1'b1; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
    chk_rd = 1'b1; e_rdata = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    set_idle();

    txn(1'b1, 2'b00, 1'b0, 32'h00001003, 32'h000000A5, 32'h0,        0,  1'b0);
    txn(1'b0, 2'b01, 1'b1, 32'h00002002, 32'h0,        32'h80011234, 0,  1'b0);
    txn(1'b0, 2'b01, 1'b0, 32'h00002002, 32'h0,        32'h80011234, 2,  1'b0);
    txn(1'b0, 2'b00, 1'b0, 32'h00002001, 32'h0,        32'h11223344, 0,  1'b0);
    txn(1'b0, 2'b10, 1'b0, 32'h00003002, 32'h0,        32'h0,        0,  1'b0);
    txn(1'b1, 2'b10, 1'b0, 32'h00003002, 32'h12345678, 32'h0,        0,  1'b0);
    txn(1'b0, 2'b01, 1'b1, 32'h00001001, 32'h0,        32'h0,        0,  1'b0);
    txn(1'b1, 2'b11, 1'b0, 32'h00001000, 32'h0,        32'h0,        0,  1'b0);
    txn(1'b0, 2'b00, 1'b1, 32'h00005003, 32'h0,        32'h80FF0000, 99, 1'b1);
    txn(1'b1, 2'b01, 1'b0, 32'h00000012, 32'hCAFEBEEF, 32'h0,        1,  1'b0);
    txn(1'b1, 2'b10, 1'b0, 32'h00000020, 32'h89ABCDEF, 32'h0,        3,  1'b0);
    txn(1'b0, 2'b00, 1'b1, 32'h00000003, 32'h0,        32'h80112233, 0,  1'b0);
    txn(1'b0, 2'b10, 1'b1, 32'h00000040, 32'h0,        32'hF00DF00D, 14, 1'b0);

    // Reset during the second BUSY cycle abandons the access.
    @(posedge clk); #1;
    Req = 1'b1; We = 1'b0; Size = 2'b10; Sext = 1'b0; Addr = 32'h00004000;
    set_idle(); e_stall = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; Req = 1'b0; bus.BusAck = 1'b1;
    set_idle();
    chk_bus = 1'b1; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
    @(posedge clk); #1;
    bus.BusAck = 1'b0;
    @(posedge clk); #1;
    set_idle();
    txn(1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0, 32'h13579BDF, 0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
